// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: word-organised RAM behind a single-request FSM
// with configurable wait states, byte-lane stores and extended sub-word loads.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Datatype,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  dtype_q;
  logic        rd_q, wr_q, err_q;

  logic        req, accept;
  logic [ADDR_W-1:0] idx;
  logic        misalign, range_err, acc_err, mem_we, rd_ok;
  logic [3:0]  be;
  logic [31:0] wlane, rword, load_val;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  logic [31:0] mem [DEPTH_WORDS];

  assign req    = MemRead | MemWrite;
  assign accept = (state_q == StIdle) && req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    Busy    = 1'b0;
    case (state_q)
      StIdle: begin
        Busy = req;
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        Busy  = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StAccess;
      end
      StAccess: begin
        Busy    = 1'b1;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign idx       = addr_q[ADDR_W+1:2];
  assign misalign  = ((dtype_q == 2'b00) && (addr_q[1:0] != 2'b00)) ||
                     ((dtype_q == 2'b01) && addr_q[0]);
  assign range_err = (32'(idx) >= DEPTH_WORDS) || (addr_q[31:ADDR_W+2] != '0);
  assign acc_err   = misalign | (rd_q & wr_q) | range_err;
  assign mem_we    = (state_q == StAccess) && wr_q && !acc_err;
  assign rd_ok     = (state_q == StAccess) && rd_q && !acc_err;

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    case (dtype_q)
      2'b00: begin
        be    = 4'hF;
        wlane = wdata_q;
      end
      2'b01: begin
        be    = addr_q[1] ? 4'hC : 4'h3;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
    endcase
  end

  assign rword    = mem[idx];
  assign half_sel = addr_q[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    case (dtype_q)
      2'b00:   load_val = rword;
      2'b01:   load_val = {{16{half_sel[15]}}, half_sel};
      2'b10:   load_val = {{24{byte_sel[7]}}, byte_sel};
      default: load_val = {24'd0, byte_sel};
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dtype_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= Address;
        wdata_q <= WriteData;
        dtype_q <= Datatype;
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
      end
      if (state_q == StAccess) err_q <= acc_err;
      if (rd_ok) rdata_q <= load_val;
    end
  end

  // RAM is deliberately not reset; the write is gated by state, which is.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wlane[8*k +: 8];
      end
    end
  end

  assign ReadData = rdata_q;
  assign Done     = (state_q == StDone);
  assign Err      = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
module tb_data_mem_responder;

  logic        Clk;
  logic        rst0, rst1;
  logic [31:0] Address, WriteData;
  logic [1:0]  Datatype;
  logic        mr0, mw0, mr1, mw1;
  logic [31:0] rd0, rd1;
  logic        busy0, busy1, done0, done1, err0, err1;

  int n_pass  = 0;
  int n_total = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut0 (
    .Clk(Clk), .Rst(rst0), .Address(Address), .WriteData(WriteData),
    .MemRead(mr0), .MemWrite(mw0), .Datatype(Datatype),
    .ReadData(rd0), .Busy(busy0), .Done(done0), .Err(err0)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut1 (
    .Clk(Clk), .Rst(rst1), .Address(Address), .WriteData(WriteData),
    .MemRead(mr1), .MemWrite(mw1), .Datatype(Datatype),
    .ReadData(rd1), .Busy(busy1), .Done(done1), .Err(err1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issues one request to the selected DUT (called at posedge+1). After accept the
  // inputs are scrambled so that only the latched values can produce the result.
  task automatic xact(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] dt,
                      output int lat, output int busy_n, output logic e);
    Address   = a;
    WriteData = wd;
    Datatype  = dt;
    if (sel == 0) begin mr0 = rd; mw0 = wr; end
    else          begin mr1 = rd; mw1 = wr; end
    lat    = -1;
    busy_n = 0;
    e      = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if ((sel == 0) ? done0 : done1) begin
        lat = c;
        e   = (sel == 0) ? err0 : err1;
        break;
      end
      if ((sel == 0) ? busy0 : busy1) busy_n++;
      @(posedge Clk);
      #1;
      if (c == 0) begin
        mr0 = 1'b0; mw0 = 1'b0; mr1 = 1'b0; mw1 = 1'b0;
        Address   = ~a;
        WriteData = ~wd;
        Datatype  = ~dt;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  int   lat, bn;
  logic e;

  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    mr0 = 1'b0; mw0 = 1'b0; mr1 = 1'b0; mw1 = 1'b0;
    Address = '0; WriteData = '0; Datatype = '0;
    repeat (3) @(posedge Clk);
    #1;
    rst0 = 1'b1; rst1 = 1'b1;
    #2;
    chk("reset_rdata", rd0, 32'h0);
    chk("reset_busy", 32'(busy0), 32'h0);
    chk("reset_done", 32'(done0), 32'h0);
    chk("reset_err", 32'(err0), 32'h0);
    chk("reset_rdata_ws0", rd1, 32'h0);
    @(posedge Clk);
    #1;

    // Word store/load, two wait states
    xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, lat, bn, e);
    chk("st_word_lat", 32'(lat), 32'd4);
    chk("st_word_busy", 32'(bn), 32'd4);
    chk("st_word_err", 32'(e), 32'h0);
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b00, lat, bn, e);
    chk("ld_word_lat", 32'(lat), 32'd4);
    chk("ld_word", rd0, 32'hDEADBEEF);

    // Sub-word accesses
    xact(0, 1'b0, 1'b1, 32'h12, 32'hAAAA_AA7F, 2'b10, lat, bn, e);
    chk("st_byte_err", 32'(e), 32'h0);
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b00, lat, bn, e);
    chk("ld_word_merged", rd0, 32'hDE7FBEEF);
    xact(0, 1'b1, 1'b0, 32'h12, 32'h0, 2'b01, lat, bn, e);
    chk("ld_half_sext", rd0, 32'hFFFFDE7F);
    xact(0, 1'b1, 1'b0, 32'h13, 32'h0, 2'b10, lat, bn, e);
    chk("ld_byte_sext", rd0, 32'hFFFFFFDE);
    xact(0, 1'b1, 1'b0, 32'h12, 32'h0, 2'b10, lat, bn, e);
    chk("ld_byte_sext_pos", rd0, 32'h0000007F);
    xact(0, 1'b1, 1'b0, 32'h13, 32'h0, 2'b11, lat, bn, e);
    chk("ld_byte_zext", rd0, 32'h000000DE);
    xact(0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 2'b01, lat, bn, e);
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b00, lat, bn, e);
    chk("ld_after_half_st", rd0, 32'hDE7F5678);

    // Error cases
    xact(0, 1'b1, 1'b0, 32'h11, 32'h0, 2'b00, lat, bn, e);
    chk("err_word_misalign", 32'(e), 32'h1);
    chk("err_word_lat", 32'(lat), 32'd4);
    chk("err_rdata_kept", rd0, 32'hDE7F5678);
    xact(0, 1'b0, 1'b1, 32'h13, 32'hFFFF_0000, 2'b01, lat, bn, e);
    chk("err_half_misalign", 32'(e), 32'h1);
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b00, lat, bn, e);
    chk("err_half_no_write", rd0, 32'hDE7F5678);
    chk("ok_err_low", 32'(e), 32'h0);
    xact(0, 1'b1, 1'b1, 32'h10, 32'h0, 2'b00, lat, bn, e);
    chk("err_rd_and_wr", 32'(e), 32'h1);
    xact(0, 1'b1, 1'b0, 32'd4096, 32'h0, 2'b00, lat, bn, e);
    chk("err_range", 32'(e), 32'h1);
    xact(0, 1'b0, 1'b1, 32'h8000_0010, 32'h0, 2'b00, lat, bn, e);
    chk("err_upper_bits", 32'(e), 32'h1);
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b00, lat, bn, e);
    chk("err_upper_no_alias", rd0, 32'hDE7F5678);

    // Zero wait states
    xact(1, 1'b0, 1'b1, 32'h40, 32'h1122_3344, 2'b00, lat, bn, e);
    chk("ws0_st_lat", 32'(lat), 32'd2);
    chk("ws0_st_busy", 32'(bn), 32'd2);
    xact(1, 1'b1, 1'b0, 32'h40, 32'h0, 2'b00, lat, bn, e);
    chk("ws0_ld_lat", 32'(lat), 32'd2);
    chk("ws0_ld_latched", rd1, 32'h1122_3344);

    // Reset during the wait state of a store
    xact(0, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 2'b00, lat, bn, e);
    Address = 32'h20; WriteData = 32'h5555_5555; Datatype = 2'b00; mw0 = 1'b1;
    @(posedge Clk);
    #1;
    mw0  = 1'b0;
    #1;
    chk("mid_busy_before_rst", 32'(busy0), 32'h1);
    rst0 = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy0), 32'h0);
    @(posedge Clk);
    #1;
    rst0 = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    xact(0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b00, lat, bn, e);
    chk("mid_rst_next_lat", 32'(lat), 32'd4);
    chk("mid_rst_no_write", rd0, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
